// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one memory port among NREQ masters, with bounded locked bursts.
// Optional macro ARB_PRIO0_EN gives master 0 (cpu0) absolute priority at every arbitration.
`timescale 1ns/1ps
module mem_bus_arbiter #(
   parameter int NREQ     = 4,
   parameter int AW       = 16,
   parameter int DW       = 16,
   parameter int MAX_HOLD = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ-1:0]    lock,
   input  logic [NREQ-1:0]    wr,
   input  logic [NREQ*AW-1:0] addr,
   input  logic [NREQ*DW-1:0] wdata,
   input  logic [DW-1:0]      mem_rdata,
   output logic [NREQ-1:0]    gnt,
   output logic [AW-1:0]      mem_addr,
   output logic [DW-1:0]      mem_wdata,
   output logic               mem_wr,
   output logic [DW-1:0]      rdata,
   output logic [NREQ-1:0]    rvalid,
   output logic               busy
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int HW = $clog2(MAX_HOLD + 2);
   localparam logic [HW-1:0] HOLD_LAST = (MAX_HOLD > 0) ? HW'(MAX_HOLD - 1) : '0;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_GRANTED = 2'd1,
      ST_TURN    = 2'd2
   } state_t;

   state_t          state_q;
   logic [NREQ-1:0] gnt_q;
   logic [NREQ-1:0] rvalid_q;
   logic [DW-1:0]   rdata_q;
   logic [IW-1:0]   ptr_q;
   logic [HW-1:0]   hold_q;
   logic [HW-1:0]   hold_d;

   logic [AW-1:0]   addr_arr  [NREQ];
   logic [DW-1:0]   wdata_arr [NREQ];

   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_unpack
         assign addr_arr[gi]  = addr[(gi+1)*AW-1 -: AW];
         assign wdata_arr[gi] = wdata[(gi+1)*DW-1 -: DW];
      end
   endgenerate

   // Decode the current grantee; all cur_* stay zero while nothing is granted.
   logic [IW-1:0] cur_idx;
   logic          cur_req;
   logic          cur_lock;
   logic          cur_wr;
   logic          others_pending;

   always_comb begin
      cur_idx  = '0;
      cur_req  = 1'b0;
      cur_lock = 1'b0;
      cur_wr   = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt_q[i]) begin
            cur_idx  = IW'(i);
            cur_req  = req[i];
            cur_lock = lock[i];
            cur_wr   = wr[i];
         end
      end
   end

   assign others_pending = |(req & ~gnt_q);
   assign hold_d         = hold_q + 1'b1;

   assign mem_addr  = (|gnt_q) ? addr_arr[cur_idx]  : '0;
   assign mem_wdata = (|gnt_q) ? wdata_arr[cur_idx] : '0;
   assign mem_wr    = cur_req & cur_wr;

   // Round-robin scan starting just after the last winner.
   logic [IW-1:0]   scan_idx;
   logic [IW-1:0]   win_idx;
   logic            win_vld;
   logic            win_prio0;
   logic [NREQ-1:0] win_onehot;

   always_comb begin
      scan_idx  = '0;
      win_idx   = '0;
      win_vld   = 1'b0;
      win_prio0 = 1'b0;
      for (int i = 1; i <= NREQ; i++) begin
         scan_idx = IW'((int'(ptr_q) + i) % NREQ);
         if (!win_vld && req[scan_idx]) begin
            win_vld = 1'b1;
            win_idx = scan_idx;
         end
      end
`ifdef ARB_PRIO0_EN
      if (req[0]) begin
         win_vld   = 1'b1;
         win_idx   = '0;
         win_prio0 = 1'b1;
      end
`endif
   end

   assign win_onehot = NREQ'(1) << win_idx;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         gnt_q    <= '0;
         rvalid_q <= '0;
         rdata_q  <= '0;
         ptr_q    <= IW'(NREQ - 1);
         hold_q   <= '0;
      end else begin
         rvalid_q <= '0;
         case (state_q)
            ST_IDLE, ST_TURN: begin
               hold_q <= '0;
               if (win_vld) begin
                  state_q <= ST_GRANTED;
                  gnt_q   <= win_onehot;
                  if (!win_prio0) ptr_q <= win_idx;
               end else begin
                  state_q <= ST_IDLE;
                  gnt_q   <= '0;
               end
            end
            ST_GRANTED: begin
               if (!cur_req) begin
                  // Request dropped: not a transfer, and it overrides hold expiry.
                  state_q <= ST_IDLE;
                  gnt_q   <= '0;
                  hold_q  <= '0;
               end else begin
                  if (!cur_wr) begin
                     rvalid_q <= gnt_q;
                     rdata_q  <= mem_rdata;
                  end
                  if (!cur_lock) begin
                     hold_q <= '0;
                     if (others_pending) begin
                        state_q <= ST_TURN;
                        gnt_q   <= '0;
                     end
                  end else if (others_pending && (MAX_HOLD != 0)) begin
                     if (hold_q == HOLD_LAST) begin
                        state_q <= ST_TURN;
                        gnt_q   <= '0;
                        hold_q  <= '0;
                     end else begin
                        hold_q <= hold_d;
                     end
                  end
               end
            end
            default: begin
               state_q <= ST_IDLE;
               gnt_q   <= '0;
               hold_q  <= '0;
            end
         endcase
      end
   end

   assign gnt    = gnt_q;
   assign rvalid = rvalid_q;
   assign rdata  = rdata_q;
   assign busy   = (state_q == ST_GRANTED);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: stimulus pushes expected bus cycles, a negedge monitor pops them.
`timescale 1ns/1ps
module tb_mem_bus_arbiter;

   localparam int NREQ = 4;
   localparam int AW   = 16;
   localparam int DW   = 16;

   logic               clk = 1'b0;
   logic               reset;
   logic [NREQ-1:0]    req, lock, wr;
   logic [NREQ*AW-1:0] addr;
   logic [NREQ*DW-1:0] wdata;
   logic [DW-1:0]      mem_rdata;
   logic [NREQ-1:0]    gnt, rvalid;
   logic [AW-1:0]      mem_addr;
   logic [DW-1:0]      mem_wdata, rdata;
   logic               mem_wr, busy;

   mem_bus_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .MAX_HOLD(8)) dut (
      .clk(clk), .reset(reset), .req(req), .lock(lock), .wr(wr),
      .addr(addr), .wdata(wdata), .mem_rdata(mem_rdata),
      .gnt(gnt), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr(mem_wr),
      .rdata(rdata), .rvalid(rvalid), .busy(busy)
   );

   always #5 clk = ~clk;

   // Memory model: read data is the address scrambled with a constant.
   assign mem_rdata = mem_addr ^ 16'hA5A5;

   typedef struct {
      string       name;
      logic [3:0]  g;
      logic [15:0] a;
      logic [15:0] wd;
      logic        w;
      logic [3:0]  rv;
      logic [15:0] rd;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
      checks++;
      if (act !== req_v) begin
         errors++;
         $display("FAIL %s: got %h required %h", name, act, req_v);
      end
   endtask

   task automatic push(input string n, input logic [3:0] g, input logic [15:0] a,
                       input logic [15:0] wd, input logic w, input logic [3:0] rv,
                       input logic [15:0] rd);
      exp_t e;
      e.name = n; e.g = g; e.a = a; e.wd = wd; e.w = w; e.rv = rv; e.rd = rd;
      exp_q.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_dut();
      tick();
      reset = 1'b1; req = '0; lock = '0; wr = '0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   // Monitor: any cycle with a grant or read-valid must match the next scoreboard entry.
   always @(negedge clk) begin
      if (gnt != '0 || rvalid != '0) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_cycle: got gnt=%b rvalid=%b with no entry queued", gnt, rvalid);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (gnt !== e.g || mem_addr !== e.a || mem_wdata !== e.wd || mem_wr !== e.w ||
                rvalid !== e.rv || (e.rv != '0 && rdata !== e.rd)) begin
               errors++;
               $display("FAIL %s: got gnt=%b addr=%h wdata=%h wr=%b rvalid=%b rdata=%h required gnt=%b addr=%h wdata=%h wr=%b rvalid=%b rdata=%h",
                        e.name, gnt, mem_addr, mem_wdata, mem_wr, rvalid, rdata,
                        e.g, e.a, e.wd, e.w, e.rv, e.rd);
            end else begin
               $display("ok %s: gnt=%b addr=%h wr=%b rvalid=%b rdata=%h",
                        e.name, gnt, mem_addr, mem_wr, rvalid, rdata);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; req = '0; lock = '0; wr = '0;
      addr  = {16'h0033, 16'h0100, 16'h0021, 16'h0010};
      wdata = {16'h4444, 16'hBEEF, 16'h2222, 16'h1111};
      repeat (3) tick();
      @(negedge clk);
      chk("rst_gnt", 32'(gnt), 0);
      chk("rst_rvalid", 32'(rvalid), 0);
      chk("rst_rdata", 32'(rdata), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_mem_wr", 32'(mem_wr), 0);
      chk("rst_mem_addr", 32'(mem_addr), 0);
      chk("rst_mem_wdata", 32'(mem_wdata), 0);
      tick();
      reset = 1'b0;

      // 1: single read by master 0
      tick(); req = 4'b0001;
      tick(); push("t1_grant", 4'b0001, 16'h0010, 16'h1111, 1'b0, 4'b0000, 16'h0);
      @(negedge clk); chk("t1_busy", 32'(busy), 1);
      tick(); req = 4'b0000;
              push("t1_rdata", 4'b0001, 16'h0010, 16'h1111, 1'b0, 4'b0001, 16'hA5B5);
      tick(); @(negedge clk); chk("t1_idle_gnt", 32'(gnt), 0);

      // 2: masters 1 and 2 alternate through TURN cycles
      reset_dut();
      tick(); req = 4'b0110;
      tick(); push("t2_g1a", 4'b0010, 16'h0021, 16'h2222, 1'b0, 4'b0000, 16'h0);
      tick(); push("t2_turn1", 4'b0000, 16'h0, 16'h0, 1'b0, 4'b0010, 16'hA584);
      tick(); push("t2_g2a", 4'b0100, 16'h0100, 16'hBEEF, 1'b0, 4'b0000, 16'h0);
      tick(); push("t2_turn2", 4'b0000, 16'h0, 16'h0, 1'b0, 4'b0100, 16'hA4A5);
      tick(); push("t2_g1b", 4'b0010, 16'h0021, 16'h2222, 1'b0, 4'b0000, 16'h0);
      tick(); push("t2_turn3", 4'b0000, 16'h0, 16'h0, 1'b0, 4'b0010, 16'hA584);
      tick(); push("t2_g2b", 4'b0100, 16'h0100, 16'hBEEF, 1'b0, 4'b0000, 16'h0);
      tick(); req = 4'b0000;
              push("t2_turn4", 4'b0000, 16'h0, 16'h0, 1'b0, 4'b0100, 16'hA4A5);
      tick(); @(negedge clk); chk("t2_idle_gnt", 32'(gnt), 0);

      // 4: master 2 writes BEEF to 0100 (ptr=2 so master 2 wins)
      tick(); req = 4'b0100; wr = 4'b0100;
      tick(); push("t4_write", 4'b0100, 16'h0100, 16'hBEEF, 1'b1, 4'b0000, 16'h0);
      tick(); req = 4'b0000; wr = 4'b0000;
              push("t4_after", 4'b0100, 16'h0100, 16'hBEEF, 1'b0, 4'b0000, 16'h0);
      tick(); @(negedge clk);
      chk("t4_idle_gnt", 32'(gnt), 0);
      chk("t4_no_rvalid", 32'(rvalid), 0);

      // 3: locked master 3 holds 8 cycles against master 0, then TURN, then master 0
      tick(); req = 4'b1001; lock = 4'b1000;
      tick(); push("t3_hold0", 4'b1000, 16'h0033, 16'h4444, 1'b0, 4'b0000, 16'h0);
      for (int k = 1; k < 8; k++) begin
         tick(); push($sformatf("t3_hold%0d", k), 4'b1000, 16'h0033, 16'h4444, 1'b0, 4'b1000, 16'hA596);
      end
      tick(); push("t3_turn", 4'b0000, 16'h0, 16'h0, 1'b0, 4'b1000, 16'hA596);
      tick(); req = 4'b0000; lock = 4'b0000;
              push("t3_g0", 4'b0001, 16'h0010, 16'h1111, 1'b0, 4'b0000, 16'h0);
      tick(); @(negedge clk); chk("t3_idle_gnt", 32'(gnt), 0);

      // 5: reset during a read grant to master 2, then master 3 wins from the reset pointer
      tick(); req = 4'b0100;
      tick(); push("t5_g2", 4'b0100, 16'h0100, 16'hBEEF, 1'b0, 4'b0000, 16'h0);
              reset = 1'b1;
      tick(); reset = 1'b0; req = 4'b1000;
      @(negedge clk);
      chk("t5_rst_gnt", 32'(gnt), 0);
      chk("t5_rst_rvalid", 32'(rvalid), 0);
      chk("t5_rst_mem_wr", 32'(mem_wr), 0);
      chk("t5_rst_busy", 32'(busy), 0);
      tick(); req = 4'b0000;
              push("t5_g3", 4'b1000, 16'h0033, 16'h4444, 1'b0, 4'b0000, 16'h0);
      tick(); @(negedge clk); chk("t5_idle_gnt", 32'(gnt), 0);

      // 6: master 1 streaming, req[0] rises: one transfer, TURN, then master 0
      tick(); req = 4'b0010;
      tick(); push("t6_g1a", 4'b0010, 16'h0021, 16'h2222, 1'b0, 4'b0000, 16'h0);
      tick(); req = 4'b0011;
              push("t6_g1b", 4'b0010, 16'h0021, 16'h2222, 1'b0, 4'b0010, 16'hA584);
      tick(); push("t6_turn", 4'b0000, 16'h0, 16'h0, 1'b0, 4'b0010, 16'hA584);
      tick(); req = 4'b0000;
              push("t6_g0", 4'b0001, 16'h0010, 16'h1111, 1'b0, 4'b0000, 16'h0);
      tick(); @(negedge clk); chk("t6_idle_gnt", 32'(gnt), 0);

      // 7: masters 0 and 2 request together
      tick(); req = 4'b0101;
      tick(); req = 4'b0000;
`ifdef ARB_PRIO0_EN
      push("t7_prio0", 4'b0001, 16'h0010, 16'h1111, 1'b0, 4'b0000, 16'h0);
`else
      push("t7_rr", 4'b0100, 16'h0100, 16'hBEEF, 1'b0, 4'b0000, 16'h0);
`endif
      tick(); @(negedge clk); chk("t7_idle_gnt", 32'(gnt), 0);

      tick();
      tick();
      chk("sb_drained", 32'(exp_q.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
Shares the single external memory port (address/data/wr) among NREQ bus masters: the cpu0 core, the program loader, the debug reader and the DMA slot. It performs round-robin arbitration with a registered grant and supports locked bursts with a bounded hold time. It drives the muxed address, write data and write strobe toward memory. Read data is returned with a per-requester valid pulse.

Parameters:
NREQ, 4, number of requesters (2..8)
AW, 16, address width
DW, 16, data width
MAX_HOLD, 8, maximum consecutive granted cycles while others wait (0 = unlimited)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
req  in  NREQ  request per master, held until done
lock  in  NREQ  keep grant across transfers (burst)
wr  in  NREQ  1 = write, 0 = read, per master
addr  in  NREQ*AW  flattened addresses; master i at [(i+1)*AW-1 -: AW]
wdata  in  NREQ*DW  flattened write data, same packing as addr
mem_rdata  in  DW  combinational read data from memory
gnt  out  NREQ  one-hot grant, registered
mem_addr  out  AW  address to memory
mem_wdata  out  DW  write data to memory
mem_wr  out  1  write strobe to memory
rdata  out  DW  registered read data, broadcast to all masters
rvalid  out  NREQ  one-cycle pulse to the master whose read completed
busy  out  1  a grant is active

Behaviour:
- Reset values: gnt=0, rvalid=0, rdata=0, busy=0, mem_wr=0, mem_addr=0, mem_wdata=0.
- Reset state: state=IDLE, rr pointer=NREQ-1 (master 0 wins first), hold_cnt=0.
- States:
  - IDLE: no grant.
  - GRANTED: exactly one gnt bit set.
  - TURN: one forced idle turnaround cycle, gnt=0, mem_wr=0.
- Arbitration: evaluated in IDLE, and in TURN's exit cycle. Scan req starting at ptr+1, modulo NREQ; the first set bit wins. gnt asserts the next cycle (1-cycle latency) and ptr becomes the winner.
- Transfer: every cycle with gnt[g] & req[g] is one transfer.
  - mem_addr and mem_wdata come combinationally from master g; mem_wr = wr[g].
  - When gnt=0, mem_addr, mem_wdata and mem_wr are all 0.
  - Read transfer: rdata <= mem_rdata and rvalid[g] <= 1 next cycle. Read latency is 1 cycle from the transfer.
- GRANTED exits:
  - req[g]=0 → IDLE next cycle. The dropping cycle is not a transfer, and arbitration in IDLE follows normally.
  - lock[g]=0 and any other req pending → grant drops after this one transfer → TURN.
  - lock[g]=0 and no other req → stay in GRANTED (back-to-back transfers, no gap).
  - lock[g]=1: stay in GRANTED. hold_cnt increments on each granted cycle while another req is pending. When hold_cnt reaches MAX_HOLD-1, this transfer is the last → TURN.
  - hold_cnt clears on any state change.
- TURN → IDLE-equivalent arbitration. The grant registers the cycle after TURN.
- Simultaneous events:
  - req drop and hold expiry in the same cycle → IDLE; the drop wins and there is no TURN.
  - A new request arriving in the same cycle as a release is considered at the next arbitration.
- Reset mid-transfer: all outputs return to reset values on the next edge. Any pending rvalid is discarded.
- busy = (state==GRANTED).

Optional Feature:
ARB_PRIO0_EN
- Defined:
  - Master 0 (cpu0) wins every arbitration when req[0]=1, regardless of ptr.
  - An unlocked grantee is released after its current transfer whenever req[0] is pending.
  - A locked grantee still holds until its MAX_HOLD expiry.
  - ptr is not updated when master 0 wins.
- Undefined: pure round-robin as above.

Test Plan:
1. After reset, req=4'b0001 and wr[0]=0 with addr0=16'h0010 → gnt=0001 next cycle; mem_addr=0010; the next cycle rdata equals mem_rdata and rvalid=0001.
2. req=4'b0110 from IDLE (ptr=3), unlocked → gnt 0010, one transfer, TURN (gnt=0, mem_wr=0), then gnt 0100; order 1,2,1,2 while both are held.
3. Master 3 with lock=1 holds, master 0 requests, MAX_HOLD=8 → exactly 8 granted cycles for master 3, one TURN cycle, then gnt=0001.
4. Master 2 writes wdata=16'hBEEF to addr 16'h0100 → mem_wr=1, mem_addr=0100, mem_wdata=BEEF in the granted cycle; rvalid stays 0.
5. reset asserted while gnt=0100 and a read is in flight → next cycle gnt=0, rvalid=0, mem_wr=0; afterwards req=1000 → gnt=1000 (ptr reset).
6. With ARB_PRIO0_EN defined, unlocked master 1 is streaming and req[0] rises → master 1 completes one transfer, TURN, then gnt=0001, even with ptr=0.
